// File: rtl/dds_wave_core.sv
// dds_wave_core
// DDS front end: a phase accumulator drives the shared ROM address, a fixed
// square-wave ROM is read synchronously, and a debounced 4-key panel selects
// the waveform with a held one-hot register plus one-cycle press strobes.
// rst_n asserts asynchronously. Its release is expected to arrive already
// synchronised to clk from the system reset controller.
module dds_wave_core #(
   parameter int ACC_W   = 32,
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int DEB_CYC = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ACC_W-1:0]  freqctrl,
   input  logic [3:0]        key_in,
   output logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] rec_q,
   output logic [3:0]        key_sel,
   output logic [3:0]        key_pulse
);

   localparam int CNT_W = (DEB_CYC > 2) ? $clog2(DEB_CYC) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DEB_CYC - 2);

   // Square-wave contents: the lower half of the table is full scale, the
   // upper half is zero. The table is fixed, so it is expressed as a function.
   function automatic logic [DATA_W-1:0] square_sample(input logic [ADDR_W-1:0] a);
      logic [DATA_W-1:0] v;
      if (a[ADDR_W-1] == 1'b0) begin
         v = {DATA_W{1'b1}};
      end else begin
         v = {DATA_W{1'b0}};
      end
      return v;
   endfunction

   logic [ACC_W-1:0] acc_r;
   logic [ACC_W-1:0] acc_next_s;
   logic [3:0]       sync1_r;
   logic [3:0]       s_key_r;
   logic [3:0]       prev_r;
   logic [CNT_W-1:0] cnt_r;
   logic [3:0]       k_st_r;
   logic             load_s;
   logic [3:0]       press_s;
   logic [3:0]       sel_next_s;

   // Next accumulator value; wraps naturally modulo 2^ACC_W.
   always_comb begin
      acc_next_s = acc_r + freqctrl;
   end

   // Phase accumulator and address register, both updated on the same edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_r <= {ACC_W{1'b0}};
         addr  <= {ADDR_W{1'b0}};
      end else begin
         acc_r <= acc_next_s;
         addr  <= acc_next_s[ACC_W-1 -: ADDR_W];
      end
   end

   // Synchronous ROM read; rec_q lags addr by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rec_q <= {DATA_W{1'b0}};
      end else begin
         rec_q <= square_sample(addr);
      end
   end

   // Two-flop synchroniser for the raw keys and previous-cycle copy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 4'b1111;
         s_key_r <= 4'b1111;
         prev_r  <= 4'b1111;
      end else begin
         sync1_r <= key_in;
         s_key_r <= sync1_r;
         prev_r  <= s_key_r;
      end
   end

   // Stability counter: restarts on any change, saturates at DEB_CYC-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (s_key_r != prev_r) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_r != CNT_MAX) begin
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Accept on the single cycle the counter steps onto its saturation value,
   // detect presses against the old accepted state, pick highest index for select.
   always_comb begin
      load_s     = 1'b0;
      press_s    = 4'b0000;
      sel_next_s = key_sel;
      if ((s_key_r == prev_r) && (cnt_r == CNT_LOAD)) begin
         load_s  = 1'b1;
         press_s = k_st_r & ~s_key_r;
      end else begin
         load_s  = 1'b0;
         press_s = 4'b0000;
      end
      if (press_s[3]) begin
         sel_next_s = 4'b1000;
      end else if (press_s[2]) begin
         sel_next_s = 4'b0100;
      end else if (press_s[1]) begin
         sel_next_s = 4'b0010;
      end else if (press_s[0]) begin
         sel_next_s = 4'b0001;
      end else begin
         sel_next_s = key_sel;
      end
   end

   // Accepted key state, press strobes and held waveform select.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k_st_r    <= 4'b1111;
         key_pulse <= 4'b0000;
         key_sel   <= 4'b1000;
      end else begin
         if (load_s) begin
            k_st_r <= s_key_r;
         end else begin
            k_st_r <= k_st_r;
         end
         key_pulse <= press_s;
         key_sel   <= sel_next_s;
      end
   end

endmodule

// File: tb/tb_dds_wave_core.sv
// Self-checking bench for dds_wave_core (DEB_CYC = 16).
// A reference model updated once per clock pushes expected {addr, rec_q}
// into a scoreboard queue; key presses push expected strobe patterns.
module tb_dds_wave_core;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] freqctrl = 32'd0;
   logic [3:0]  key_in = 4'b1111;
   logic [7:0]  addr;
   logic [7:0]  rec_q;
   logic [3:0]  key_sel;
   logic [3:0]  key_pulse;

   int checks = 0;
   int failures = 0;

   logic [31:0] m_acc = 32'd0;
   logic [7:0]  m_addr = 8'd0;
   logic [7:0]  m_rec = 8'd0;
   bit          sb_on = 1'b0;
   logic [15:0] exp_q[$];
   logic [3:0]  kq[$];

   dds_wave_core #(.ACC_W(32), .ADDR_W(8), .DATA_W(8), .DEB_CYC(16)) dut (
      .clk(clk), .rst_n(rst_n), .freqctrl(freqctrl), .key_in(key_in),
      .addr(addr), .rec_q(rec_q), .key_sel(key_sel), .key_pulse(key_pulse)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] rom_exp(input logic [7:0] a);
      return (a < 8'd128) ? 8'hFF : 8'h00;
   endfunction

   // Advance one clock, update the reference model and push its expectation.
   task automatic tick();
      logic [7:0] nrec;
      @(posedge clk);
      if (!rst_n) begin
         m_acc = 32'd0; m_addr = 8'd0; m_rec = 8'd0;
      end else begin
         nrec   = rom_exp(m_addr);
         m_acc  = m_acc + freqctrl;
         m_addr = m_acc[31:24];
         m_rec  = nrec;
      end
      if (sb_on) exp_q.push_back({m_addr, m_rec});
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", addr); end
      checks++; if (rec_q !== 8'h00) begin failures++; $display("FAIL reset_rec got=%h exp=00", rec_q); end
      checks++; if (key_sel !== 4'b1000) begin failures++; $display("FAIL reset_sel got=%b exp=1000", key_sel); end
      checks++; if (key_pulse !== 4'b0000) begin failures++; $display("FAIL reset_pulse got=%b exp=0000", key_pulse); end
      rst_n = 1'b1;
   endtask

   task automatic test_sweep();
      logic [15:0] e;
      int ff_cnt;
      ff_cnt = 0;
      sb_on = 1'b1; exp_q.delete();
      freqctrl = 32'h0100_0000;
      for (int i = 0; i < 300; i++) begin
         tick();
         e = exp_q.pop_front();
         checks++; if (addr !== e[15:8]) begin failures++; $display("FAIL sweep_addr cyc=%0d got=%h exp=%h", i, addr, e[15:8]); end
         checks++; if (rec_q !== e[7:0]) begin failures++; $display("FAIL sweep_rec cyc=%0d got=%h exp=%h", i, rec_q, e[7:0]); end
         if (i >= 1 && i < 257 && rec_q === 8'hFF) ff_cnt++;
      end
      checks++; if (ff_cnt != 128) begin failures++; $display("FAIL sweep_ff_count got=%0d exp=128", ff_cnt); end
      sb_on = 1'b0;
   endtask

   task automatic test_half_and_freeze();
      logic [15:0] e;
      logic [7:0]  held;
      freqctrl = 32'd0;
      rst_n = 1'b0; tick(); rst_n = 1'b1;
      sb_on = 1'b1; exp_q.delete();
      freqctrl = 32'h8000_0000;
      for (int i = 0; i < 10; i++) begin
         tick();
         e = exp_q.pop_front();
         checks++; if (addr !== e[15:8]) begin failures++; $display("FAIL half_addr cyc=%0d got=%h exp=%h", i, addr, e[15:8]); end
         checks++; if (rec_q !== e[7:0]) begin failures++; $display("FAIL half_rec cyc=%0d got=%h exp=%h", i, rec_q, e[7:0]); end
      end
      checks++; if (addr !== 8'h00) begin failures++; $display("FAIL half_end_addr got=%h exp=00", addr); end
      freqctrl = 32'd0;
      held = addr;
      for (int i = 0; i < 10; i++) begin
         tick();
         e = exp_q.pop_front();
         checks++; if (addr !== e[15:8]) begin failures++; $display("FAIL freeze_addr cyc=%0d got=%h exp=%h", i, addr, e[15:8]); end
         checks++; if (rec_q !== e[7:0]) begin failures++; $display("FAIL freeze_rec cyc=%0d got=%h exp=%h", i, rec_q, e[7:0]); end
      end
      checks++; if (addr !== held) begin failures++; $display("FAIL freeze_hold got=%h exp=%h", addr, held); end
      sb_on = 1'b0;
   endtask

   task automatic test_short_press();
      int pulses;
      pulses = 0;
      freqctrl = 32'd0;
      key_in = 4'b1101;
      for (int i = 0; i < 10; i++) begin tick(); if (key_pulse !== 4'b0000) pulses++; end
      key_in = 4'b1111;
      for (int i = 0; i < 40; i++) begin tick(); if (key_pulse !== 4'b0000) pulses++; end
      checks++; if (pulses != 0) begin failures++; $display("FAIL short_pulses got=%0d exp=0", pulses); end
      checks++; if (key_sel !== 4'b1000) begin failures++; $display("FAIL short_sel got=%b exp=1000", key_sel); end
   endtask

   task automatic test_bounce_press();
      int pulses;
      logic [3:0] e;
      pulses = 0;
      key_in = 4'b1011; tick();
      key_in = 4'b1111; tick();
      key_in = 4'b1011;
      kq.push_back(4'b0100);
      for (int lat = 1; lat <= 40; lat++) begin
         tick();
         if (key_pulse !== 4'b0000) begin
            pulses++;
            if (kq.size() == 0) begin
               checks++; failures++; $display("FAIL bounce_extra_pulse got=%b exp=0000", key_pulse);
            end else begin
               e = kq.pop_front();
               checks++; if (key_pulse !== e) begin failures++; $display("FAIL bounce_pulse got=%b exp=%b", key_pulse, e); end
               checks++; if (lat < 17 || lat > 19) begin failures++; $display("FAIL bounce_latency got=%0d exp=17..19", lat); end
            end
         end
      end
      checks++; if (pulses != 1) begin failures++; $display("FAIL bounce_count got=%0d exp=1", pulses); end
      checks++; if (key_sel !== 4'b0100) begin failures++; $display("FAIL bounce_sel got=%b exp=0100", key_sel); end
      kq.delete();
      pulses = 0;
      key_in = 4'b1111;
      for (int i = 0; i < 40; i++) begin tick(); if (key_pulse !== 4'b0000) pulses++; end
      checks++; if (pulses != 0) begin failures++; $display("FAIL release_pulses got=%0d exp=0", pulses); end
      checks++; if (key_sel !== 4'b0100) begin failures++; $display("FAIL release_sel got=%b exp=0100", key_sel); end
   endtask

   task automatic test_dual_press();
      int pulses;
      logic [3:0] e;
      pulses = 0;
      key_in = 4'b0101;
      kq.push_back(4'b1010);
      for (int i = 0; i < 40; i++) begin
         tick();
         if (key_pulse !== 4'b0000) begin
            pulses++;
            if (kq.size() == 0) begin
               checks++; failures++; $display("FAIL dual_extra_pulse got=%b exp=0000", key_pulse);
            end else begin
               e = kq.pop_front();
               checks++; if (key_pulse !== e) begin failures++; $display("FAIL dual_pulse got=%b exp=%b", key_pulse, e); end
            end
         end
      end
      checks++; if (pulses != 1) begin failures++; $display("FAIL dual_count got=%0d exp=1", pulses); end
      checks++; if (key_sel !== 4'b1000) begin failures++; $display("FAIL dual_sel got=%b exp=1000", key_sel); end
      kq.delete();
      key_in = 4'b1111;
      repeat (40) tick();
   endtask

   task automatic test_reset_mid();
      logic [15:0] e;
      logic [31:0] prod;
      sb_on = 1'b1; exp_q.delete();
      freqctrl = 32'd85899;
      key_in = 4'b1110;
      for (int i = 0; i < 30; i++) begin
         tick();
         e = exp_q.pop_front();
         checks++; if (addr !== e[15:8]) begin failures++; $display("FAIL mid_pre_addr cyc=%0d got=%h exp=%h", i, addr, e[15:8]); end
      end
      checks++; if (key_sel !== 4'b0001) begin failures++; $display("FAIL mid_pre_sel got=%b exp=0001", key_sel); end
      rst_n = 1'b0;
      #2;
      checks++; if (addr !== 8'h00) begin failures++; $display("FAIL mid_async_addr got=%h exp=00", addr); end
      checks++; if (rec_q !== 8'h00) begin failures++; $display("FAIL mid_async_rec got=%h exp=00", rec_q); end
      checks++; if (key_sel !== 4'b1000) begin failures++; $display("FAIL mid_async_sel got=%b exp=1000", key_sel); end
      exp_q.delete();
      m_acc = 32'd0; m_addr = 8'd0; m_rec = 8'd0;
      tick(); tick();
      void'(exp_q.pop_front()); void'(exp_q.pop_front());
      key_in = 4'b1111;
      rst_n = 1'b1;
      for (int n = 1; n <= 400; n++) begin
         tick();
         e = exp_q.pop_front();
         checks++; if (addr !== e[15:8]) begin failures++; $display("FAIL mid_addr n=%0d got=%h exp=%h", n, addr, e[15:8]); end
         checks++; if (rec_q !== e[7:0]) begin failures++; $display("FAIL mid_rec n=%0d got=%h exp=%h", n, rec_q, e[7:0]); end
      end
      prod = 32'd85899 * 32'd400;
      e[15:8] = prod[31:24];
      checks++; if (addr !== e[15:8]) begin failures++; $display("FAIL mid_acc_n400 got=%h exp=%h", addr, e[15:8]); end
      sb_on = 1'b0;
   endtask

   initial begin
      test_reset();
      test_sweep();
      test_half_and_freeze();
      test_short_press();
      test_bounce_press();
      test_dual_press();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
